// File: rtl/led_scan_sequencer_pkg.sv
// led_scan_sequencer_pkg: shared sizes, defaults and state encoding for the LED scan sequencer
package led_scan_sequencer_pkg;

    localparam int unsigned N_OUTPUTS        = 36;
    localparam int unsigned SEL_W            = 6;
    localparam int unsigned PRESCALE_DEFAULT = 1000;
    localparam int unsigned BLANK_DEFAULT    = 50;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef logic [SEL_W-1:0]     sel_t;
    typedef logic [N_OUTPUTS-1:0] frame_t;

    function automatic sel_t next_slot(input sel_t s);
        return (s == sel_t'(N_OUTPUTS - 1)) ? '0 : s + sel_t'(1);
    endfunction

    // The demux routes select k to out[N_OUTPUTS-1-k], so the frame is read mirrored.
    function automatic logic frame_bit(input frame_t f, input sel_t s);
        return f[sel_t'(N_OUTPUTS - 1) - s];
    endfunction

endpackage

// File: rtl/led_scan_sequencer_scan_prescaler.sv
// led_scan_sequencer_scan_prescaler: per-slot cycle counter with slot tick and next-cycle blanking flag
module led_scan_sequencer_scan_prescaler #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic blank
);

    localparam int unsigned CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign tick    = cnt == CW'(PRESCALE - 1);
    assign cnt_nxt = (clr || tick) ? '0 : cnt + CW'(1);
    // Blanking is judged on the count the next cycle will show, so A can be registered alongside it.
    assign blank   = cnt_nxt < CW'(BLANK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: double-buffered frame scanner driving a 1-to-N select demux
module led_scan_sequencer
    import led_scan_sequencer_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned BLANK    = BLANK_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_OUTPUTS-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [SEL_W-1:0]     input_sel,
    output logic                 A,
    output logic                 frame_done
);

    state_t state;
    state_t state_nxt;
    sel_t   slot;
    sel_t   slot_nxt;
    frame_t active;
    frame_t active_nxt;
    frame_t shadow;
    frame_t shadow_nxt;
    logic   pending;
    logic   pending_nxt;
    logic   scanning;
    logic   boundary;
    logic   load;
    logic   accept;
    logic   a_nxt;
    logic   tick;
    logic   blank;

    led_scan_sequencer_scan_prescaler #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_scan_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (!scanning),
        .tick  (tick),
        .blank (blank)
    );

    // Dropping enable parks the scan immediately, even mid-slot; no boundary is taken on that cycle.
    always_comb begin
        state_nxt   = enable ? SCAN : IDLE;
        scanning    = state == SCAN && enable;
        boundary    = scanning && tick && slot == sel_t'(N_OUTPUTS - 1);
        load        = pending && (boundary || (state == IDLE && enable));
        accept      = frame_valid && frame_ready;
        slot_nxt    = !scanning ? '0 : tick ? next_slot(slot) : slot;
        active_nxt  = load ? shadow : active;
        shadow_nxt  = accept ? frame_data : shadow;
        pending_nxt = load ? 1'b0 : accept ? 1'b1 : pending;
        a_nxt       = state_nxt == SCAN && !blank && frame_bit(active_nxt, slot_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            frame_ready <= 1'b1;
            frame_done  <= 1'b0;
            A           <= 1'b0;
        end else begin
            state       <= state_nxt;
            slot        <= slot_nxt;
            active      <= active_nxt;
            shadow      <= shadow_nxt;
            pending     <= pending_nxt;
            frame_ready <= !pending_nxt;
            frame_done  <= boundary;
            A           <= a_nxt;
        end
    end

    assign input_sel = slot;

endmodule
